// File: rtl/register_bist_scheduler_if.sv
// Handshake and data bundle between the BIST scheduler and the registers under test.
// The scheduler is the slave side; the bench or top-level FSM is the master side.
interface register_bist_scheduler_if #(
  parameter int WIDTH  = 4,
  parameter int N_REGS = 4
);
  logic                      start;
  logic [N_REGS*WIDTH-1:0]   reg_q;
  logic [N_REGS-1:0]         bist_on;
  logic [WIDTH-1:0]          test_d;
  logic                      busy;
  logic                      done;
  logic [N_REGS-1:0]         fail_map;
  logic                      all_pass;

  modport master (
    output start,
    output reg_q,
    input  bist_on,
    input  test_d,
    input  busy,
    input  done,
    input  fail_map,
    input  all_pass
  );

  modport slave (
    input  start,
    input  reg_q,
    output bist_on,
    output test_d,
    output busy,
    output done,
    output fail_map,
    output all_pass
  );
endinterface

// File: rtl/register_bist_scheduler.sv
// BIST sequencer: walks one counting pattern across N_REGS registers in turn,
// compares each captured value one cycle later and records per-register fails.
module register_bist_scheduler #(
  parameter int WIDTH  = 4,
  parameter int N_REGS = 4
) (
  input logic                  clk,
  input logic                  rst,
  register_bist_scheduler_if.slave bus
);
  localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [IW-1:0]     LAST = IW'(N_REGS - 1);
  localparam logic [N_REGS-1:0] ONE  = N_REGS'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_CHECK = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  pat_q, pat_d;
  logic [N_REGS-1:0] fail_q, fail_d;

  logic [WIDTH-1:0]  cur;
  logic [N_REGS-1:0] on;
  logic [WIDTH-1:0]  td;
  logic              busy;
  logic              dn;
  logic [N_REGS-1:0] fvis;

  // Select the captured value of the register currently under test.
  always_comb begin
    cur = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (idx_q == IW'(i)) cur = bus.reg_q[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    fail_d  = fail_q;
    on      = '0;
    td      = '0;
    busy    = 1'b0;
    dn      = 1'b0;
    fvis    = fail_q;
    case (state_q)
      S_IDLE: begin
        fvis = '0;
        if (bus.start) begin
          fail_d  = '0;
          idx_d   = '0;
          pat_d   = '0;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        on      = ONE << idx_q;
        td      = pat_q;
        busy    = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        on   = ONE << idx_q;
        td   = pat_q;
        busy = 1'b1;
        if (cur != pat_q) begin
          fail_d  = fail_q | (ONE << idx_q);
          state_d = S_NEXT;
        end else if (&pat_q) begin
          state_d = S_NEXT;
        end else begin
          pat_d   = pat_q + WIDTH'(1);
          state_d = S_APPLY;
        end
      end
      S_NEXT: begin
        busy  = 1'b1;
        pat_d = '0;
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        dn = 1'b1;
        if (bus.start) begin
          fail_d  = '0;
          idx_d   = '0;
          pat_d   = '0;
          state_d = S_APPLY;
        end
      end
      default: begin
        // Illegal encoding: behave like IDLE and scrub all run state.
        fvis    = '0;
        idx_d   = '0;
        pat_d   = '0;
        fail_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.bist_on  = on;
  assign bus.test_d   = td;
  assign bus.busy     = busy;
  assign bus.done     = dn;
  assign bus.fail_map = fvis;
  assign bus.all_pass = dn & ~|fvis;
endmodule

// File: tb/tb_register_bist_scheduler.sv
// Directed bench for register_bist_scheduler: default 4x4 instance plus a
// single-register 2-bit instance, each driving a behavioural register model.
module tb_register_bist_scheduler;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  register_bist_scheduler_if #(.WIDTH(4), .N_REGS(4)) bus ();
  register_bist_scheduler_if #(.WIDTH(2), .N_REGS(1)) bus2 ();

  register_bist_scheduler #(.WIDTH(4), .N_REGS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  register_bist_scheduler #(.WIDTH(2), .N_REGS(1)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rq [4];
  logic [3:0] smask [4];
  logic [1:0] rq2;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) rq[i] <= 4'h0;
      else if (bus.bist_on[i]) rq[i] <= bus.test_d & ~smask[i];
    end
    if (rst) rq2 <= 2'b0;
    else if (bus2.bist_on[0]) rq2 <= bus2.test_d;
  end

  assign bus.reg_q  = {rq[3], rq[2], rq[1], rq[0]};
  assign bus2.reg_q = rq2;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bist_on"}, 32'(bus.bist_on), 0);
    chk({tag, "_test_d"}, 32'(bus.test_d), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_fail_map"}, 32'(bus.fail_map), 0);
    chk({tag, "_all_pass"}, 32'(bus.all_pass), 0);
  endtask

  // Pulse start, then count busy cycles until done; cycle 1 is the first APPLY.
  task automatic run(input int pa, input int pb, input bit seq,
                     output int busy_n, output int done_cyc,
                     output logic [3:0] ff1);
    int r;
    int pos;
    busy_n   = 0;
    done_cyc = 0;
    ff1      = 4'hx;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == 1) ff1 = bus.fail_map;
      if (bus.busy) busy_n++;
      if (seq && cyc <= 132) begin
        r   = (cyc - 1) / 33;
        pos = (cyc - 1) % 33;
        if (pos == 32) begin
          chk("seq_next_on", 32'(bus.bist_on), 0);
          chk("seq_next_d", 32'(bus.test_d), 0);
        end else begin
          chk("seq_on", 32'(bus.bist_on), 32'(1) << r);
          chk("seq_d", 32'(bus.test_d), 32'(pos / 2));
        end
      end
      bus.start = (cyc == pa || cyc == pb);
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  int         bn;
  int         dc;
  logic [3:0] f1;

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4; i++) smask[i] = 4'h0;
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    // Clean run with full pattern-sequence check
    run(0, 0, 1'b1, bn, dc, f1);
    chk("clean_busy", 32'(bn), 132);
    chk("clean_done_cyc", 32'(dc), 133);
    chk("clean_fail_map", 32'(bus.fail_map), 0);
    chk("clean_all_pass", 32'(bus.all_pass), 1);

    // Start pulses during the run must be ignored
    run(10, 50, 1'b0, bn, dc, f1);
    chk("ign_busy", 32'(bn), 132);
    chk("ign_done_cyc", 32'(dc), 133);
    chk("ign_fail_map", 32'(bus.fail_map), 0);
    chk("ign_all_pass", 32'(bus.all_pass), 1);

    // Reset during CHECK of register 1 with pat=7
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (48) @(negedge clk);
    chk("mid_on", 32'(bus.bist_on), 32'h2);
    chk("mid_d", 32'(bus.test_d), 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    run(0, 0, 1'b1, bn, dc, f1);
    chk("post_rst_busy", 32'(bn), 132);
    chk("post_rst_all_pass", 32'(bus.all_pass), 1);

    // Register 2 bit 0 stuck-at-0
    smask[2] = 4'h1;
    run(0, 0, 1'b0, bn, dc, f1);
    chk("fault_busy", 32'(bn), 104);
    chk("fault_done_cyc", 32'(dc), 105);
    chk("fault_fail_map", 32'(bus.fail_map), 32'h4);
    chk("fault_all_pass", 32'(bus.all_pass), 0);
    chk("fault_done", 32'(bus.done), 1);

    // Fix fault, restart from DONE
    smask[2] = 4'h0;
    run(0, 0, 1'b0, bn, dc, f1);
    chk("restart_first_fail_map", 32'(f1), 0);
    chk("restart_busy", 32'(bn), 132);
    chk("restart_fail_map", 32'(bus.fail_map), 0);
    chk("restart_all_pass", 32'(bus.all_pass), 1);

    // Single register, WIDTH=2
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    chk("single_first_on", 32'(bus2.bist_on), 1);
    chk("single_first_busy", 32'(bus2.busy), 1);
    bn = 0;
    dc = 0;
    for (int c = 1; c <= 100; c++) begin
      if (bus2.done) begin
        dc = c;
        break;
      end
      if (bus2.busy) bn++;
      @(negedge clk);
    end
    chk("single_busy", 32'(bn), 9);
    chk("single_done_cyc", 32'(dc), 10);
    chk("single_fail_map", 32'(bus2.fail_map), 0);
    chk("single_all_pass", 32'(bus2.all_pass), 1);
    chk("single_on_done", 32'(bus2.bist_on), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_bist_scheduler.md
# register_bist_scheduler

Central BIST sequencer for a bank of 4-bit pipeline registers with a BIST input mux. A single pattern source is shared across `N_REGS` registers under test, and each register is tested in turn. For each register the block enables that register's test-mux select, drives a counting pattern, checks the captured value one cycle later, and records a per-register fail bit. Software or a top-level FSM starts a run with `start`, then reads `fail_map` and `all_pass` once `done` is asserted.

## Interface
- `WIDTH`, 4: data width of each register under test; patterns run 0 .. 2^WIDTH-1.
- `N_REGS`, 4: number of registers sequenced; must be ≥1.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: run request; sampled only in IDLE or DONE.
- `reg_q`, in, N_REGS*WIDTH: captured register outputs, packed; register i occupies bits [i*WIDTH +: WIDTH].
- `bist_on`, out, N_REGS: one-hot test-mux select; at most one bit is high.
- `test_d`, out, WIDTH: shared pattern bus, wired to every register's test input.
- `busy`, out, 1: high in APPLY, CHECK and NEXT.
- `done`, out, 1: high while in DONE.
- `fail_map`, out, N_REGS: bit i is set when register i miscompared during the current or last run.
- `all_pass`, out, 1: `done & ~|fail_map`.

## Operation
- State registers: FSM state, index `idx` (clog2 of N_REGS, min 1 bit), pattern `pat` (WIDTH bits), `fail_map`.
- **IDLE:** all outputs low or zero. `start=1` clears `fail_map`, `idx` and `pat`, then goes to APPLY.
- **APPLY:** `bist_on[idx]=1`, `test_d=pat`. Always goes to CHECK on the next cycle.
- **CHECK:** `bist_on[idx]=1` and `test_d=pat` are held. Compare `reg_q[idx*WIDTH +: WIDTH]` against `pat`.
  - Match with `pat` = all-ones: go to NEXT.
  - Match otherwise: `pat` increments, go to APPLY.
  - Mismatch: set `fail_map[idx]`, go to NEXT. The remaining patterns for this register are skipped.
- **NEXT:** `bist_on=0`, `test_d=0`, `pat` cleared.
  - If `idx==N_REGS-1`, go to DONE.
  - Otherwise `idx` increments, go to APPLY.
- **DONE:** `bist_on=0`, `test_d=0`, `done=1`. `fail_map` is held.
  - `start=1` clears `fail_map`, `idx` and `pat`, then goes to APPLY, which restarts the run.
  - Otherwise stays in DONE.
- `start` while `busy` is ignored; no queuing.
- `pat` increments modulo 2^WIDTH, but never wraps in practice because the all-ones pattern exits to NEXT.
- `idx` never exceeds N_REGS-1.
- Undefined or illegal FSM encodings recover to IDLE on the next edge, with outputs as in IDLE.

## Timing
- Reset: `rst=1` at an edge forces IDLE, `idx=0`, `pat=0`, `fail_map=0`.
  - All outputs then read 0: `bist_on`, `test_d`, `busy`, `done`, `fail_map`, `all_pass`.
  - Reset takes priority over `start` and over any state, including mid-run. No partial results are retained.
- Start latency: `start` high at edge k puts the FSM in APPLY for cycle k+1, with `busy=1` and `bist_on[0]=1`.
- The register under test captures `test_d` at the edge ending APPLY. CHECK compares during the following cycle (one-cycle register latency).
- Cycles per register: a fully passing register takes 2*2^WIDTH + 1 cycles, which is 33 at WIDTH=4. A register failing at pattern p takes 2(p+1) + 1 cycles.
- Run length with defaults, all passing: 132 busy cycles. `done` rises 133 cycles after the `start` edge.
- `all_pass` and `done` are updated in the same cycle (combinational from registered state).
- `bist_on` changes only at state edges and never has two bits high. In NEXT, `bist_on` is 0 for one cycle between registers.

## Test plan
- **Clean run.** Defaults, ideal registers, one-cycle `start` pulse. Expect `busy` for 132 cycles, then `done=1`, `fail_map=4'b0000`, `all_pass=1`. `test_d` steps 0..15 on each register in turn.
- **Stuck-at fault.** Register 2, bit 0 stuck-at-0. Expect:
  - a miscompare in CHECK with `pat=1`, after which `fail_map[2]` is set;
  - register 3 is still fully tested;
  - final `fail_map=4'b0100`, `all_pass=0`;
  - `busy` for 33+33+5+33 = 104 cycles.
- **Ignored start.** Pulse `start` during cycles 10 and 50 of a run. Expect no effect: same 132-cycle length and results as the clean run.
- **Reset mid-run.** Assert `rst` in CHECK of register 1, `pat=7`. Next cycle expect IDLE with every output 0. A subsequent `start` runs a full clean 132-cycle pass.
- **Restart from DONE.** After the fault run, fix the fault and pulse `start` in DONE. Expect `fail_map` cleared on the first APPLY cycle, and a clean completion with `all_pass=1`.
- **Single register.** `N_REGS=1`, `WIDTH=2`, ideal register. Expect `busy` for 9 cycles, `done=1`, `fail_map=1'b0`, `bist_on` never leaves `1'b1` or `1'b0`.
